// File: rtl/exe_pipe_ctrl.sv
// exe_pipe_ctrl: execute-stage sequencing controller for the RV32 core.
// Keeps a shadow copy of the EX, MEM and WB instructions. From that state it
// drives the ALU forwarding selects, load-use stalls, branch flushes and the
// multi-cycle hold of EX while a mul/div completes.
module exe_pipe_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int LONG_LAT   = 4,
   parameter int CNT_W      = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  id_long_op,
   input  logic                  ex_branch_taken,
   output logic                  stall_if,
   output logic                  stall_id,
   output logic                  bubble_ex,
   output logic                  flush_id,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic                  busy
);

   // A long op must stall for at least one extra cycle, and the countdown
   // register has to be able to hold LONG_LAT-1.
   if (LONG_LAT < 2) begin : g_bad_long_lat
      $error("exe_pipe_ctrl: LONG_LAT must be at least 2");
   end
   if (LONG_LAT > (2 ** CNT_W)) begin : g_bad_cnt_w
      $error("exe_pipe_ctrl: CNT_W too narrow for LONG_LAT-1");
   end

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_LONG = 1'b1;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic                  rs1_used;
      logic                  rs2_used;
      logic [REG_ADDR_W-1:0] rd;
      logic                  we;
      logic                  load;
      logic                  long_op;
      logic                  done;
   } ex_slot_t;

   ex_slot_t              ex_q;
   ex_slot_t              id_slot;
   logic                  mem_valid;
   logic [REG_ADDR_W-1:0] mem_rd;
   logic                  mem_we;
   logic                  wb_valid;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic                  wb_we;
   logic [0:0]            state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  started_q;

   logic                  in_run;
   logic                  long_start;
   logic                  luh;
   logic                  mem_writing;
   logic                  wb_writing;

   // Package the ID inputs the way they will sit in the EX slot.
   always_comb begin
      id_slot          = '0;
      id_slot.valid    = id_valid;
      id_slot.rs1      = id_rs1;
      id_slot.rs2      = id_rs2;
      id_slot.rs1_used = id_rs1_used;
      id_slot.rs2_used = id_rs2_used;
      id_slot.rd       = id_rd;
      id_slot.we       = id_reg_write;
      id_slot.load     = id_mem_read;
      id_slot.long_op  = id_long_op;
      id_slot.done     = 1'b0;
   end

   // Hazard detection; x0 is never a real producer.
   always_comb begin
      in_run      = (state_q == ST_RUN);
      mem_writing = mem_valid & mem_we & (mem_rd != '0);
      wb_writing  = wb_valid & wb_we & (wb_rd != '0);
      long_start  = in_run & ex_q.valid & ex_q.long_op & ~ex_q.done;
      luh         = in_run & ex_q.valid & ex_q.load & (ex_q.rd != '0) & id_valid &
                    ((id_rs1_used & (id_rs1 == ex_q.rd)) |
                     (id_rs2_used & (id_rs2 == ex_q.rd)));
   end

   // Operand forwarding; the younger MEM result wins over WB.
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (ex_q.rs1_used && mem_writing && (mem_rd == ex_q.rs1)) begin
         fwd_a = 2'b01;
      end else if (ex_q.rs1_used && wb_writing && (wb_rd == ex_q.rs1)) begin
         fwd_a = 2'b10;
      end
      if (ex_q.rs2_used && mem_writing && (mem_rd == ex_q.rs2)) begin
         fwd_b = 2'b01;
      end else if (ex_q.rs2_used && wb_writing && (wb_rd == ex_q.rs2)) begin
         fwd_b = 2'b10;
      end
   end

   // Pipeline enables; everything stays quiet in the first cycle after reset.
   always_comb begin
      stall_id  = started_q & (long_start | ~in_run);
      flush_id  = started_q & in_run & ~long_start & ex_branch_taken;
      bubble_ex = started_q & in_run & ~long_start & (luh | ex_branch_taken);
      stall_if  = stall_id | (started_q & luh & ~flush_id);
      busy      = ~in_run;
   end

   // Long-op FSM: count down the remaining EX occupancy, then release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_RUN;
         cnt_q     <= '0;
         started_q <= 1'b0;
      end else begin
         started_q <= 1'b1;
         if (state_q == ST_RUN) begin
            if (long_start) begin
               state_q <= ST_LONG;
               cnt_q   <= CNT_W'(LONG_LAT - 2);
            end
         end else if (cnt_q == '0) begin
            state_q <= ST_RUN;
         end else begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   // Shadow pipeline advance; a held EX slot sends a bubble into MEM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_q      <= '0;
         mem_valid <= 1'b0;
         mem_rd    <= '0;
         mem_we    <= 1'b0;
         wb_valid  <= 1'b0;
         wb_rd     <= '0;
         wb_we     <= 1'b0;
      end else begin
         wb_valid <= mem_valid;
         wb_rd    <= mem_rd;
         wb_we    <= mem_we;
         if (stall_id) begin
            if (!in_run && (cnt_q == '0)) begin
               ex_q.done <= 1'b1;
            end
            mem_valid <= 1'b0;
            mem_rd    <= '0;
            mem_we    <= 1'b0;
         end else begin
            ex_q      <= bubble_ex ? '0 : id_slot;
            mem_valid <= ex_q.valid;
            mem_rd    <= ex_q.rd;
            mem_we    <= ex_q.we;
         end
      end
   end

endmodule

// File: tb/tb_exe_pipe_ctrl.sv
// tb_exe_pipe_ctrl: directed bench for exe_pipe_ctrl with LONG_LAT = 4.
// Inputs change and outputs are sampled 1ns after each falling clock edge.
module tb_exe_pipe_ctrl;

   logic       clk;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_rs1_used;
   logic       id_rs2_used;
   logic [4:0] id_rd;
   logic       id_reg_write;
   logic       id_mem_read;
   logic       id_long_op;
   logic       ex_branch_taken;
   logic       stall_if;
   logic       stall_id;
   logic       bubble_ex;
   logic       flush_id;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;
   logic       busy;

   int n_checks;
   int n_fail;

   exe_pipe_ctrl #(.REG_ADDR_W(5), .LONG_LAT(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_long_op(id_long_op), .ex_branch_taken(ex_branch_taken),
      .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
      .flush_id(flush_id), .fwd_a(fwd_a), .fwd_b(fwd_b), .busy(busy)
   );

   // Free-running 10ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Present one instruction in ID.
   task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic r1u, input logic r2u, input logic [4:0] rd,
                                input logic we, input logic mr, input logic lo);
      id_valid     = v;
      id_rs1       = rs1;
      id_rs2       = rs2;
      id_rs1_used  = r1u;
      id_rs2_used  = r2u;
      id_rd        = rd;
      id_reg_write = we;
      id_mem_read  = mr;
      id_long_op   = lo;
   endtask

   task automatic apply_nop();
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Advance through one rising edge to the next sample point.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic drain();
      apply_nop();
      ex_branch_taken = 1'b0;
      step();
      step();
      step();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
      ex_branch_taken = 1'b1;
      step();
      n_checks++;
      if ({stall_if, stall_id, bubble_ex, flush_id, fwd_a, fwd_b, busy} !== 9'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs: got %b expected %b",
                  {stall_if, stall_id, bubble_ex, flush_id, fwd_a, fwd_b, busy}, 9'b0);
      end
      apply_nop();
      rst = 1'b1;
      #1;
      n_checks++;
      if ({stall_if, stall_id, bubble_ex, flush_id, fwd_a, fwd_b, busy} !== 9'b0) begin
         n_fail++;
         $display("[TB] FAIL first_cycle_outputs: got %b expected %b",
                  {stall_if, stall_id, bubble_ex, flush_id, fwd_a, fwd_b, busy}, 9'b0);
      end
      step();
      n_checks++;
      if ({stall_if, bubble_ex, flush_id} !== 3'b011) begin
         n_fail++;
         $display("[TB] FAIL branch_alone: got %b expected %b",
                  {stall_if, bubble_ex, flush_id}, 3'b011);
      end
      drain();
   endtask

   task automatic test_forwarding();
      applyStimulus(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
      #1;
      n_checks++;
      if ({stall_if, bubble_ex, fwd_a, fwd_b} !== 6'b000000) begin
         n_fail++;
         $display("[TB] FAIL fwd_no_producer: got %b expected %b",
                  {stall_if, bubble_ex, fwd_a, fwd_b}, 6'b000000);
      end
      step();
      applyStimulus(1'b1, 5'd2, 5'd5, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
      #1;
      n_checks++;
      if ({stall_if, fwd_a, fwd_b} !== 5'b00100) begin
         n_fail++;
         $display("[TB] FAIL fwd_a_from_mem: got %b expected %b",
                  {stall_if, fwd_a, fwd_b}, 5'b00100);
      end
      step();
      apply_nop();
      #1;
      n_checks++;
      if ({stall_if, fwd_a, fwd_b} !== 5'b00010) begin
         n_fail++;
         $display("[TB] FAIL fwd_b_from_wb: got %b expected %b",
                  {stall_if, fwd_a, fwd_b}, 5'b00010);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, 5'd10, 5'd10, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0);
      step();
      apply_nop();
      #1;
      n_checks++;
      if ({fwd_a, fwd_b} !== 4'b0101) begin
         n_fail++;
         $display("[TB] FAIL mem_priority: got %b expected %b", {fwd_a, fwd_b}, 4'b0101);
      end
      drain();
   endtask

   task automatic test_load_use();
      applyStimulus(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
      step();
      applyStimulus(1'b1, 5'd6, 5'd1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
      #1;
      n_checks++;
      if ({stall_if, stall_id, bubble_ex, flush_id} !== 4'b1010) begin
         n_fail++;
         $display("[TB] FAIL luh_stall: got %b expected %b",
                  {stall_if, stall_id, bubble_ex, flush_id}, 4'b1010);
      end
      step();
      n_checks++;
      if ({stall_if, stall_id, bubble_ex, flush_id, fwd_a, fwd_b} !== 8'b0) begin
         n_fail++;
         $display("[TB] FAIL luh_one_cycle: got %b expected %b",
                  {stall_if, stall_id, bubble_ex, flush_id, fwd_a, fwd_b}, 8'b0);
      end
      step();
      apply_nop();
      #1;
      n_checks++;
      if ({stall_if, fwd_a, fwd_b} !== 5'b01000) begin
         n_fail++;
         $display("[TB] FAIL luh_fwd_from_wb: got %b expected %b",
                  {stall_if, fwd_a, fwd_b}, 5'b01000);
      end
      drain();
   endtask

   task automatic test_x0();
      applyStimulus(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0);
      #1;
      n_checks++;
      if ({stall_if, bubble_ex} !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL x0_no_stall: got %b expected %b", {stall_if, bubble_ex}, 2'b00);
      end
      step();
      applyStimulus(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      #1;
      n_checks++;
      if ({fwd_a, fwd_b} !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL x0_no_fwd_mem: got %b expected %b", {fwd_a, fwd_b}, 4'b0000);
      end
      step();
      applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0);
      #1;
      n_checks++;
      if ({stall_if, bubble_ex} !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL x0_load_no_luh: got %b expected %b", {stall_if, bubble_ex}, 2'b00);
      end
      step();
      apply_nop();
      #1;
      n_checks++;
      if ({stall_if, fwd_a, fwd_b} !== 5'b00000) begin
         n_fail++;
         $display("[TB] FAIL x0_load_no_fwd: got %b expected %b", {stall_if, fwd_a, fwd_b}, 5'b00000);
      end
      drain();
   endtask

   task automatic test_long_op();
      logic [3:0] obs;
      logic [3:0] exp;
      applyStimulus(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b1);
      step();
      applyStimulus(1'b1, 5'd11, 5'd4, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) ex_branch_taken = 1'b1;
         #1;
         obs = {stall_if, stall_id, busy, bubble_ex};
         exp = {(i < 4), (i < 4), (i >= 1 && i <= 3), 1'b0};
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL long_cycle_%0d: got %b expected %b", i, obs, exp);
         end
         if (i == 2) begin
            n_checks++;
            if (flush_id !== 1'b0) begin
               n_fail++;
               $display("[TB] FAIL long_ignores_branch: got %b expected %b", flush_id, 1'b0);
            end
            ex_branch_taken = 1'b0;
         end
         step();
      end
      apply_nop();
      #1;
      n_checks++;
      if ({stall_if, busy, fwd_a, fwd_b} !== 6'b000100) begin
         n_fail++;
         $display("[TB] FAIL long_dep_fwd: got %b expected %b",
                  {stall_if, busy, fwd_a, fwd_b}, 6'b000100);
      end
      drain();
   endtask

   task automatic test_branch_luh();
      applyStimulus(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
      step();
      applyStimulus(1'b1, 5'd6, 5'd1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
      ex_branch_taken = 1'b1;
      #1;
      n_checks++;
      if ({stall_if, bubble_ex, flush_id} !== 3'b011) begin
         n_fail++;
         $display("[TB] FAIL branch_over_luh: got %b expected %b",
                  {stall_if, bubble_ex, flush_id}, 3'b011);
      end
      step();
      ex_branch_taken = 1'b0;
      apply_nop();
      #1;
      n_checks++;
      if ({stall_if, fwd_a, fwd_b} !== 5'b00000) begin
         n_fail++;
         $display("[TB] FAIL branch_bubbled_ex: got %b expected %b",
                  {stall_if, fwd_a, fwd_b}, 5'b00000);
      end
      drain();
   endtask

   task automatic test_reset_mid_long();
      applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
      step();
      applyStimulus(1'b1, 5'd13, 5'd3, 1'b1, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1);
      step();
      apply_nop();
      step();
      n_checks++;
      if ({busy, stall_if, fwd_a} !== 4'b1110) begin
         n_fail++;
         $display("[TB] FAIL pre_reset_long: got %b expected %b", {busy, stall_if, fwd_a}, 4'b1110);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if ({stall_if, stall_id, bubble_ex, flush_id, fwd_a, fwd_b, busy} !== 9'b0) begin
         n_fail++;
         $display("[TB] FAIL async_reset_long: got %b expected %b",
                  {stall_if, stall_id, bubble_ex, flush_id, fwd_a, fwd_b, busy}, 9'b0);
      end
      step();
      step();
      applyStimulus(1'b1, 5'd13, 5'd16, 1'b1, 1'b1, 5'd17, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      apply_nop();
      #1;
      n_checks++;
      if ({stall_if, busy, fwd_a, fwd_b} !== 6'b0) begin
         n_fail++;
         $display("[TB] FAIL no_stale_fwd: got %b expected %b", {stall_if, busy, fwd_a, fwd_b}, 6'b0);
      end
      step();
      n_checks++;
      if ({stall_if, busy, fwd_a, fwd_b} !== 6'b0) begin
         n_fail++;
         $display("[TB] FAIL no_stale_long: got %b expected %b", {stall_if, busy, fwd_a, fwd_b}, 6'b0);
      end
      drain();
   endtask

   // Run every scenario in order and report.
   initial begin
      n_checks        = 0;
      n_fail          = 0;
      rst             = 1'b0;
      ex_branch_taken = 1'b0;
      apply_nop();
      test_reset();
      test_forwarding();
      test_back_to_back();
      test_load_use();
      test_x0();
      test_long_op();
      test_branch_luh();
      test_reset_mid_long();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
